// File: rtl/vram_wr_poster.sv
// Posted-write bridge from the VDC strobe bus to one toggle-handshake SDRAM VRAM port.
// Writes queue in a small FIFO; reads bypass the queue and forward from posted writes on a hit.
module vram_wr_poster #(
  parameter int ADDR_W   = 15,
  parameter int DEPTH    = 4,
  parameter int READ_LAT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_din,
  input  logic              cpu_we,
  input  logic              cpu_rd,
  output logic              cpu_busy,
  output logic [15:0]       cpu_dout,
  output logic              cpu_rd_valid,
  output logic              sd_req,
  input  logic              sd_ack,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [15:0]       sd_din,
  output logic              sd_we,
  input  logic [15:0]       sd_dout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(READ_LAT + 1);

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_WR_WAIT,
    S_RD_WAIT,
    S_RD_DATA
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [15:0]       fifo_data [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  logic              fly_valid;
  logic [ADDR_W-1:0] fly_addr;
  logic [15:0]       fly_data;

  logic              rd_pend;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [LW-1:0]     lat_cnt;

  // Request toggle has no reset: a handshake in flight must survive reset.
  logic req_q = 1'b0;

  logic        ack_match;
  logic        accept_wr, accept_rd;
  logic        hit;
  logic [15:0] hit_data;
  logic        issue_rd, issue_wr, fly_clear, load_lat, deliver;

  assign sd_req    = req_q;
  assign ack_match = (sd_ack == req_q);
  assign cpu_busy  = reset | (state == S_SYNC) | (count == CW'(DEPTH)) | rd_pend;
  assign accept_wr = cpu_we & ~cpu_busy;
  assign accept_rd = cpu_rd & ~cpu_we & ~cpu_busy;

  // Forwarding search: in-flight first, then FIFO oldest to newest so the newest match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = 16'h0000;
    if (fly_valid && fly_addr == cpu_addr) begin
      hit      = 1'b1;
      hit_data = fly_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count && fifo_addr[rd_ptr + PW'(k)] == cpu_addr) begin
        hit      = 1'b1;
        hit_data = fifo_data[rd_ptr + PW'(k)];
      end
    end
  end

  always_comb begin
    state_nx  = state;
    issue_rd  = 1'b0;
    issue_wr  = 1'b0;
    fly_clear = 1'b0;
    load_lat  = 1'b0;
    deliver   = 1'b0;
    case (state)
      S_SYNC: if (ack_match) state_nx = S_IDLE;
      S_IDLE: begin
        if (rd_pend) begin
          issue_rd = 1'b1;
          state_nx = S_RD_WAIT;
        end else if (count != '0) begin
          issue_wr = 1'b1;
          state_nx = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (ack_match) begin
          fly_clear = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (ack_match) begin
          load_lat = 1'b1;
          state_nx = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (lat_cnt == '0) begin
          deliver  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_SYNC;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!reset && (issue_rd || issue_wr)) req_q <= ~req_q;
  end

  always_ff @(posedge clk) begin
    if (accept_wr && !reset) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      fly_valid    <= 1'b0;
      fly_addr     <= '0;
      fly_data     <= '0;
      rd_pend      <= 1'b0;
      rd_addr_q    <= '0;
      lat_cnt      <= '0;
      cpu_dout     <= '0;
      cpu_rd_valid <= 1'b0;
      sd_we        <= 1'b0;
      sd_addr      <= '0;
      sd_din       <= '0;
    end else begin
      cpu_rd_valid <= 1'b0;
      count        <= count + CW'(accept_wr) - CW'(issue_wr);
      if (accept_wr) wr_ptr <= wr_ptr + PW'(1);
      if (issue_wr) begin
        rd_ptr    <= rd_ptr + PW'(1);
        fly_valid <= 1'b1;
        fly_addr  <= fifo_addr[rd_ptr];
        fly_data  <= fifo_data[rd_ptr];
        sd_we     <= 1'b1;
        sd_addr   <= fifo_addr[rd_ptr];
        sd_din    <= fifo_data[rd_ptr];
      end
      if (fly_clear) fly_valid <= 1'b0;
      if (issue_rd) begin
        sd_we   <= 1'b0;
        sd_addr <= rd_addr_q;
      end
      if (accept_rd) begin
        if (hit) begin
          cpu_dout     <= hit_data;
          cpu_rd_valid <= 1'b1;
        end else begin
          rd_pend   <= 1'b1;
          rd_addr_q <= cpu_addr;
        end
      end
      if (load_lat) lat_cnt <= LW'(READ_LAT - 1);
      else if (state == S_RD_DATA && lat_cnt != '0) lat_cnt <= lat_cnt - LW'(1);
      if (deliver) begin
        cpu_dout     <= sd_dout;
        cpu_rd_valid <= 1'b1;
        rd_pend      <= 1'b0;
      end
    end
  end

endmodule
